muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file: it takes the two source operand values (RD1/RD2) and the destination index of an M-extension instruction, computes the result over multiple cycles, and returns it with a register-write request for the WD3/A3/WE write port. While an operation is in flight it asserts `busy`, and the core holds the PC and instruction fetch.

---
 rtl/muldiv_unit_if.sv | 49 ++++
 rtl/muldiv_unit.sv | 271 +++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle between the issue stage and the iterative RV32M
// multiply/divide unit.
//
// Handshake: `start` acts as a valid strobe and `!busy` acts as ready. A
// request is accepted on a rising edge where start=1 and busy=0. `start`
// while busy=1 is dropped, not queued. Each accepted request produces exactly
// one `done` pulse, unless reset aborts it. `result`, `rd_out` and `we_out`
// are valid in the `done` cycle, and `result` holds its value until the next
// `done`.
//
// Signals:
//   start    issue strobe (sampled only while the unit is idle)
//   funct3   operation select (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   rs1_val  dividend / multiplicand
//   rs2_val  divisor / multiplier
//   rd_in    destination register index
//   busy     operation in flight (CALC or DONE)
//   done     one-cycle completion pulse
//   result   register write data
//   rd_out   register write address, latched at issue
//   we_out   register write enable (done and rd_out != 0)
// Modports: master = issue side, slave = the unit.
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            we_out;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in,
    input  busy, done, result, rd_out, we_out
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in,
    output busy, done, result, rd_out, we_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide execution unit. It takes the two source
// operand values and the destination index of an M-extension instruction. It
// runs a 32-step radix-2 shift-add multiply or restoring divide on operand
// magnitudes, fixes up the sign, and returns the result together with a
// register-write request.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   bus          muldiv_unit_if.slave (see the interface for the handshake)
//   o_dbg_state  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Timing: start accepted at edge E0. A normal op sits in CALC for cycles
// E0+1..E0+32 and raises done in E0+33. A fast-path op raises done in E0+1.
//
// Build option: define MULDIV_DIV_EN to compile the divider. Without it,
// funct3 1xx completes through the fast path with result 0, and multiply is
// unchanged.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus,
  output logic [1:0]    o_dbg_state
);

  if (XLEN != 32) begin : g_xlen_check
    $error("muldiv_unit: only XLEN=32 is supported");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [4:0]  r_cnt;
  logic [31:0] r_result;
  // Multiply: {partial product high, multiplier shifting out at the bottom}.
  // Divide:   {partial remainder, dividend/quotient shifting at the bottom}.
  logic [63:0] r_acc;
  // Multiply: multiplicand magnitude. Divide: divisor magnitude.
  logic [31:0] r_op;
  // Multiply: product sign. Divide: quotient sign.
  logic        r_neg;
`ifdef MULDIV_DIV_EN
  logic        r_neg_rem;
`endif

  // ---------------------------------------------------------------------------
  // Issue-side decode: operand signedness and magnitudes
  // ---------------------------------------------------------------------------
  logic        w_op1_neg;
  logic        w_op2_neg;
  logic [31:0] w_op1_mag;
  logic [31:0] w_op2_mag;

  always_comb begin
    w_op1_neg = 1'b0;
    w_op2_neg = 1'b0;
    case (bus.funct3)
      3'b001: begin                       // MULH: signed x signed
        w_op1_neg = bus.rs1_val[31];
        w_op2_neg = bus.rs2_val[31];
      end
      3'b010: begin                       // MULHSU: signed x unsigned
        w_op1_neg = bus.rs1_val[31];
      end
      3'b100, 3'b110: begin               // DIV, REM
        w_op1_neg = bus.rs1_val[31];
        w_op2_neg = bus.rs2_val[31];
      end
      default: begin                      // MUL, MULHU, DIVU, REMU: unsigned
      end
    endcase
  end

  assign w_op1_mag = w_op1_neg ? (32'd0 - bus.rs1_val) : bus.rs1_val;
  assign w_op2_mag = w_op2_neg ? (32'd0 - bus.rs2_val) : bus.rs2_val;

  // ---------------------------------------------------------------------------
  // Fast path: results known at issue, no iteration needed
  // ---------------------------------------------------------------------------
  logic        w_fast;
  logic [31:0] w_fast_res;

  always_comb begin
    w_fast     = 1'b0;
    w_fast_res = 32'd0;
`ifdef MULDIV_DIV_EN
    if (bus.funct3[2]) begin
      if (bus.rs2_val == 32'd0) begin
        // Divide by zero: quotient all ones, remainder is the dividend.
        w_fast     = 1'b1;
        w_fast_res = bus.funct3[1] ? bus.rs1_val : 32'hFFFF_FFFF;
      end else if (!bus.funct3[0] &&
                   (bus.rs1_val == 32'h8000_0000) &&
                   (bus.rs2_val == 32'hFFFF_FFFF)) begin
        // Signed overflow: -2^31 / -1 returns the dividend and remainder 0.
        w_fast     = 1'b1;
        w_fast_res = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
      end
    end
`else
    if (bus.funct3[2]) begin
      w_fast     = 1'b1;
      w_fast_res = 32'd0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [63:0] w_acc_next;

  // Shift-add: add the multiplicand into the high half when the current
  // multiplier bit is set. Then shift right, keeping the carry as the new MSB.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_op} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

`ifdef MULDIV_DIV_EN
  logic [32:0] w_div_sh;
  logic        w_div_ge;
  logic [32:0] w_div_diff;
  logic [31:0] w_div_rem;
  logic [63:0] w_div_next;

  // Restoring step. The remainder is always below the divisor, so the shifted
  // remainder needs 33 bits. After a successful subtract it fits in 32 bits
  // again.
  assign w_div_sh   = {r_acc[63:32], r_acc[31]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_op});
  assign w_div_diff = w_div_sh - {1'b0, r_op};
  assign w_div_rem  = w_div_ge ? w_div_diff[31:0] : w_div_sh[31:0];
  assign w_div_next = {w_div_rem, r_acc[30:0], w_div_ge};
  assign w_acc_next = r_funct3[2] ? w_div_next : w_mul_next;
`else
  assign w_acc_next = w_mul_next;
`endif

  // ---------------------------------------------------------------------------
  // Final sign fix-up and word select, taken from the last step's output
  // ---------------------------------------------------------------------------
  logic [63:0] w_prod;
  logic [31:0] w_mul_res;
  logic [31:0] w_calc_res;

  assign w_prod    = r_neg ? (64'd0 - w_acc_next) : w_acc_next;
  assign w_mul_res = (r_funct3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

`ifdef MULDIV_DIV_EN
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_quo      = r_neg     ? (32'd0 - w_acc_next[31:0])  : w_acc_next[31:0];
  assign w_rem      = r_neg_rem ? (32'd0 - w_acc_next[63:32]) : w_acc_next[63:32];
  assign w_calc_res = r_funct3[2] ? (r_funct3[1] ? w_rem : w_quo) : w_mul_res;
`else
  // Divide ops never reach CALC in this build.
  assign w_calc_res = r_funct3[2] ? 32'd0 : w_mul_res;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = w_fast ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == 5'd31) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3  <= 3'd0;
      r_rd      <= 5'd0;
      r_cnt     <= 5'd0;
      r_result  <= 32'd0;
      r_acc     <= 64'd0;
      r_op      <= 32'd0;
      r_neg     <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_neg_rem <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_funct3  <= bus.funct3;
            r_rd      <= bus.rd_in;
            r_cnt     <= 5'd0;
            r_neg     <= w_op1_neg ^ w_op2_neg;
`ifdef MULDIV_DIV_EN
            r_neg_rem <= w_op1_neg;
`endif
            if (bus.funct3[2]) begin
              // Divide: the dividend shifts through the low half.
              r_op  <= w_op2_mag;
              r_acc <= {32'd0, w_op1_mag};
            end else begin
              // Multiply: the multiplier shifts through the low half.
              r_op  <= w_op1_mag;
              r_acc <= {32'd0, w_op2_mag};
            end
            if (w_fast) begin
              r_result <= w_fast_res;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_result <= w_calc_res;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.we_out  = (r_state == S_DONE) && (r_rd != 5'd0);
  assign bus.result  = r_result;
  assign bus.rd_out  = r_rd;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed and random-operand bench for muldiv_unit. Every issued request
// pushes its expected {we, rd, result} onto exp_q. The word is popped and
// compared when done appears. Timing, busy and abort behaviour are checked
// inline.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset / watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------------
  logic [37:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  localparam int LAT_CALC = 33;
  localparam int LAT_FAST = 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] ub;
    logic        [63:0] p;
    logic        [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    r  = 32'd0;
    case (f)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0];  end
      3'b001: begin p = sa * sb;                 r = p[63:32]; end
      3'b010: begin p = sa * ub;                 r = p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
`ifdef MULDIV_DIV_EN
      3'b100: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      3'b111: r = (b == 32'd0) ? a : a % b;
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int lat_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return LAT_CALC;
`ifdef MULDIV_DIV_EN
    if (b == 32'd0) return LAT_FAST;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_FAST;
    return LAT_CALC;
`else
    return LAT_FAST;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: issue one op at the current negedge, wait for done, score it.
  // inject_at != 0 pulses a second start (fresh operands) in that busy cycle.
  // Returns at a negedge in the first idle cycle after done.
  // ---------------------------------------------------------------------------
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat, input int inject_at);
    logic [37:0] e;
    int          n;
    int          busy_n;
    logic        got;
    exp_q.push_back({(rd != 5'd0), rd, exp_res});
    bus.start   = 1'b1;
    bus.funct3  = f;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    @(posedge clk);                       // E0
    @(negedge clk);                       // cycle E0+1
    n      = 1;
    busy_n = 0;
    got    = 1'b0;
    // The operands only need to be valid in the start cycle.
    bus.start   = 1'b0;
    bus.funct3  = 3'($urandom_range(0, 7));
    bus.rs1_val = $urandom();
    bus.rs2_val = $urandom();
    bus.rd_in   = 5'($urandom_range(0, 31));
    while (n <= 100) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (inject_at != 0 && n == inject_at) begin
        bus.start   = 1'b1;
        bus.funct3  = 3'($urandom_range(0, 7));
        bus.rs1_val = $urandom();
        bus.rs2_val = $urandom();
        bus.rd_in   = 5'($urandom_range(1, 31));
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 64'(bus.result), 64'(e[31:0]));
      check({tag, "_rd_out"}, 64'(bus.rd_out), 64'(e[36:32]));
      check({tag, "_we_out"}, 64'(bus.we_out), 64'(e[37]));
    end
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    check({tag, "_done_after"}, 64'(bus.done), 64'd0);
  endtask

  // Watch a window of cycles and count any completion activity.
  task automatic watch_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.done || bus.we_out) seen++;
      @(negedge clk);
    end
    check({tag, "_no_completion"}, 64'(seen), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
`ifdef MULDIV_DIV_EN
  localparam logic [31:0] DIV_M7_2   = 32'hFFFF_FFFD;
  localparam logic [31:0] REM_M7_2   = 32'hFFFF_FFFF;
  localparam logic [31:0] DIVU_BY0   = 32'hFFFF_FFFF;
  localparam logic [31:0] REMU_BY0   = 32'h0000_1234;
  localparam logic [31:0] DIV_OVF    = 32'h8000_0000;
  localparam logic [31:0] DIV_100_5  = 32'd20;
  localparam int          LAT_DIVN   = LAT_CALC;
  localparam logic [2:0]  ABORT_F    = 3'b101;   // DIVU
`else
  localparam logic [31:0] DIV_M7_2   = 32'd0;
  localparam logic [31:0] REM_M7_2   = 32'd0;
  localparam logic [31:0] DIVU_BY0   = 32'd0;
  localparam logic [31:0] REMU_BY0   = 32'd0;
  localparam logic [31:0] DIV_OVF    = 32'd0;
  localparam logic [31:0] DIV_100_5  = 32'd0;
  localparam int          LAT_DIVN   = LAT_FAST;
  localparam logic [2:0]  ABORT_F    = 3'b011;   // MULHU: still iterates
`endif

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rrd;

    bus.start   = 1'b0;
    bus.funct3  = 3'd0;
    bus.rs1_val = 32'd0;
    bus.rs2_val = 32'd0;
    bus.rd_in   = 5'd0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset_busy",   64'(bus.busy),   64'd0);
    check("reset_done",   64'(bus.done),   64'd0);
    check("reset_we",     64'(bus.we_out), 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_rd_out", 64'(bus.rd_out), 64'd0);
    check("reset_state",  64'(dbg_state),  64'd0);

    // Multiply
    run_op("mul_7_m3",     3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, LAT_CALC, 0);
    run_op("mulh_min",     3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, LAT_CALC, 0);
    run_op("mulhu_min",    3'b011, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, LAT_CALC, 0);
    run_op("mulhsu_min",   3'b010, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'hC000_0000, LAT_CALC, 0);
    run_op("mul_rd0",      3'b000, 32'd3,         32'd4,         5'd0,  32'd12,        LAT_CALC, 0);

    // Divide (result and latency depend on whether the divider is built)
    run_op("div_m7_2",     3'b100, 32'hFFFF_FFF9, 32'd2,         5'd6,  DIV_M7_2,  LAT_DIVN, 0);
    run_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9, 32'd2,         5'd7,  REM_M7_2,  LAT_DIVN, 0);
    run_op("divu_by0",     3'b101, 32'h0000_1234, 32'd0,         5'd8,  DIVU_BY0,  LAT_FAST, 0);
    run_op("remu_by0",     3'b111, 32'h0000_1234, 32'd0,         5'd9,  REMU_BY0,  LAT_FAST, 0);
    run_op("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, DIV_OVF,   LAT_FAST, 0);
    run_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,     LAT_FAST, 0);
    run_op("div_100_5",    3'b100, 32'd100,       32'd5,         5'd12, DIV_100_5, LAT_DIVN, 0);

    // Start while busy is ignored: original result and a single completion
    run_op("busy_ignore",  3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 5'd13,
           model(3'b011, 32'hDEAD_BEEF, 32'h1234_5678), LAT_CALC, 5);
    watch_quiet("busy_ignore", 40);

    // Reset mid-operation aborts without any write
    bus.start   = 1'b1;
    bus.funct3  = ABORT_F;
    bus.rs1_val = 32'h0000_BEEF;
    bus.rs2_val = 32'd3;
    bus.rd_in   = 5'd14;
    @(posedge clk);                       // E0
    @(negedge clk);                       // E0+1
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      check("abort_pre_busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
    end
    rst = 1'b1;                           // sampled at the edge ending E0+10
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",  64'(bus.busy),  64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    watch_quiet("abort", 50);

    // Reset and start together: reset wins
    bus.start   = 1'b1;
    bus.funct3  = 3'b000;
    bus.rs1_val = 32'd9;
    bus.rs2_val = 32'd9;
    bus.rd_in   = 5'd15;
    rst         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy",   64'(bus.busy),   64'd0);
    check("rst_start_result", 64'(bus.result), 64'd0);
    watch_quiet("rst_start", 40);

    // Random operands against the reference model
    for (int i = 0; i < 10; i++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      rrd = 5'($urandom_range(0, 31));
      run_op("rnd", rf, ra, rb, rrd, model(rf, ra, rb), lat_model(rf, ra, rb), 0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
